// File: rtl/mips_mc_controller.sv
// Multi-cycle control FSM for the 8-bit MIPS datapath: byte-wise instruction fetch,
// opcode/funct decode, and all datapath enables plus the ALU function select.
module mips_mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alu_funct,
    output logic [1:0] pcsource,
    output logic       pc_en,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,
        S_FETCH2 = 4'd1,
        S_FETCH3 = 4'd2,
        S_FETCH4 = 4'd3,
        S_DECODE = 4'd4,
        S_MEMADR = 4'd5,
        S_LBRD   = 4'd6,
        S_LBWB   = 4'd7,
        S_SBWR   = 4'd8,
        S_RTEX   = 4'd9,
        S_RTWB   = 4'd10,
        S_BEQEX  = 4'd11,
        S_JEX    = 4'd12,
        S_ADDIEX = 4'd13,
        S_ADDIWB = 4'd14
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH1;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = S_FETCH1;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        iord      = 1'b0;
        irwrite   = 4'b0000;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        alu_funct = 3'b000;
        pcsource  = 2'b00;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        illegal   = 1'b0;

        case (r_state)
            // Each fetch cycle loads one IR byte lane and bumps PC by one, gated by mem_ready.
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                w_next  = r_state;
                if (mem_ready) begin
                    irwrite   = 4'b0001 << r_state[1:0];
                    w_pcwrite = 1'b1;
                    w_next    = (r_state == S_FETCH4) ? S_DECODE : state_t'(r_state + 4'd1);
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_R:         w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SB) ? S_SBWR : S_LBRD;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                w_next  = mem_ready ? S_LBWB : S_LBRD;
            end
            S_LBWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                w_next   = mem_ready ? S_FETCH1 : S_SBWR;
            end
            S_RTEX: begin
                alusrca = 1'b1;
                w_next  = S_RTWB;
                case (funct)
                    6'b100000: alu_funct = 3'b000;
                    6'b100010: alu_funct = 3'b010;
                    6'b100100: alu_funct = 3'b100;
                    6'b100101: alu_funct = 3'b101;
                    6'b101010: alu_funct = 3'b011;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH1;
                    end
                endcase
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                alu_funct = 3'b010;
                w_branch  = 1'b1;
                pcsource  = 2'b01;
            end
            S_JEX: begin
                w_pcwrite = 1'b1;
                pcsource  = 2'b10;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            default: ;
        endcase

        pc_en = w_pcwrite | (w_branch & zero);

        // Outputs are forced quiet for the whole time reset is held, not just on its edge.
        if (!rst_n) begin
            memread   = 1'b0;
            memwrite  = 1'b0;
            iord      = 1'b0;
            irwrite   = 4'b0000;
            alusrca   = 1'b0;
            alusrcb   = 2'b00;
            alu_funct = 3'b000;
            pcsource  = 2'b00;
            pc_en     = 1'b0;
            regwrite  = 1'b0;
            regdst    = 1'b0;
            memtoreg  = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class state by state and
// compares the full output vector against hand-derived per-state values.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       memread, memwrite, iord, alusrca, pc_en, regwrite, regdst, memtoreg, illegal;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alu_funct;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alu_funct(alu_funct), .pcsource(pcsource),
        .pc_en(pc_en), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {memread,memwrite,iord, irwrite, alusrca, alusrcb, alu_funct, pcsource, pc_en,
    //  regwrite,regdst,memtoreg,illegal}
    logic [19:0] w_obs;
    assign w_obs = {memread, memwrite, iord, irwrite, alusrca, alusrcb, alu_funct, pcsource,
                    pc_en, regwrite, regdst, memtoreg, illegal};

    localparam logic [19:0] E_ZERO    = 20'd0;
    localparam logic [19:0] E_FSTALL  = {3'b100, 4'b0000, 1'b0, 2'b01, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_DEC     = {3'b000, 4'b0000, 1'b0, 2'b11, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_DEC_ILL = {3'b000, 4'b0000, 1'b0, 2'b11, 3'b000, 2'b00, 1'b0, 4'b0001};
    localparam logic [19:0] E_MEMADR  = {3'b000, 4'b0000, 1'b1, 2'b10, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_LBRD    = {3'b101, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_LBWB    = {3'b000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 4'b1010};
    localparam logic [19:0] E_SBWR    = {3'b011, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_RT_SLT  = {3'b000, 4'b0000, 1'b1, 2'b00, 3'b011, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_RT_ADD  = {3'b000, 4'b0000, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 4'b0000};
    localparam logic [19:0] E_RT_ILL  = {3'b000, 4'b0000, 1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 4'b0001};
    localparam logic [19:0] E_RTWB    = {3'b000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 4'b1100};
    localparam logic [19:0] E_BEQ_T   = {3'b000, 4'b0000, 1'b1, 2'b00, 3'b010, 2'b01, 1'b1, 4'b0000};
    localparam logic [19:0] E_BEQ_N   = {3'b000, 4'b0000, 1'b1, 2'b00, 3'b010, 2'b01, 1'b0, 4'b0000};
    localparam logic [19:0] E_JEX     = {3'b000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b10, 1'b1, 4'b0000};
    localparam logic [19:0] E_ADDIWB  = {3'b000, 4'b0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 4'b1000};

    function automatic logic [19:0] fv(input logic [3:0] lane);
        return {3'b100, lane, 1'b0, 2'b01, 3'b000, 2'b00, 1'b1, 4'b0000};
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        #1;
        n_tests++;
        assert (w_obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Entered while in FETCH1; leaves the DUT in DECODE.
    task automatic fetch(input string name);
        check($sformatf("%s_fetch1", name), fv(4'b0001));
        for (int i = 1; i < 4; i++) begin
            cyc();
            check($sformatf("%s_fetch%0d", name, i + 1), fv(4'b0001 << i));
        end
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("reset_quiet%0d", i), E_ZERO);
        end
        rst_n = 1'b1;
        $display("[TB] reset released");

        // R-type SLT: 7 cycles
        op = 6'b000000; funct = 6'b101010;
        fetch("slt");
        check("slt_decode", E_DEC);
        cyc(); check("slt_rtex", E_RT_SLT);
        cyc(); check("slt_rtwb", E_RTWB);
        cyc();
        $display("[TB] R-type slt done");

        // BEQ taken then not taken: 6 cycles each
        op = 6'b000100; zero = 1'b1;
        fetch("beq1");
        check("beq1_decode", E_DEC);
        cyc(); check("beq1_ex", E_BEQ_T);
        cyc(); zero = 1'b0;
        $display("[TB] beq zero=1 done");
        fetch("beq0");
        check("beq0_decode", E_DEC);
        cyc(); check("beq0_ex", E_BEQ_N);
        cyc();
        $display("[TB] beq zero=0 done");

        // LB with 3 wait cycles in LBRD
        op = 6'b100000;
        fetch("lb");
        check("lb_decode", E_DEC);
        cyc(); check("lb_memadr", E_MEMADR);
        cyc(); mem_ready = 1'b0; check("lb_rd_wait0", E_LBRD);
        for (int i = 1; i < 3; i++) begin
            cyc(); check($sformatf("lb_rd_wait%0d", i), E_LBRD);
        end
        cyc(); mem_ready = 1'b1; check("lb_rd_done", E_LBRD);
        cyc(); check("lb_wb", E_LBWB);
        cyc();
        $display("[TB] lb with 3 wait cycles done");

        // Illegal opcode, then illegal funct
        op = 6'b111111;
        fetch("badop");
        check("badop_decode", E_DEC_ILL);
        cyc();
        op = 6'b000000; funct = 6'b000111;
        fetch("badfn");
        check("badfn_decode", E_DEC);
        cyc(); check("badfn_rtex", E_RT_ILL);
        cyc();
        $display("[TB] illegal op/funct done");

        // J with one fetch stall in FETCH1
        op = 6'b000010;
        mem_ready = 1'b0; check("j_fetch_stall", E_FSTALL);
        cyc(); mem_ready = 1'b1;
        fetch("j");
        check("j_decode", E_DEC);
        cyc(); check("j_ex", E_JEX);
        cyc();
        $display("[TB] jump with fetch stall done");

        // SB interrupted by reset inside SBWR
        op = 6'b101000;
        fetch("sb");
        check("sb_decode", E_DEC);
        cyc(); check("sb_memadr", E_MEMADR);
        cyc(); mem_ready = 1'b0; check("sb_wr", E_SBWR);
        #2 rst_n = 1'b0;
        check("sb_async_reset", E_ZERO);
        cyc(); check("sb_reset_hold", E_ZERO);
        rst_n = 1'b1; mem_ready = 1'b1;
        op = 6'b001000;
        $display("[TB] sb interrupted by reset");

        // ADDI after reset: restart at FETCH1, no stray memwrite
        fetch("addi");
        check("addi_decode", E_DEC);
        cyc(); check("addi_ex", E_MEMADR);
        cyc(); check("addi_wb", E_ADDIWB);
        cyc(); check("addi_next_fetch1", fv(4'b0001));
        $display("[TB] addi after reset done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
